// File: rtl/mem_req_queue.sv
// mem_req_queue: decoupling buffer between the request/write-data side of the
// memory system and the external main memory port. Write requests are held
// back until a full line of beats is buffered, and beats are only released
// once their owning write request has gone downstream.
module mem_req_queue #(
    parameter int ADDR_BITS  = 28,
    parameter int TAG_BITS   = 5,
    parameter int DATA_BITS  = 128,
    parameter int BEATS      = 4,
    parameter int REQ_DEPTH  = 4,
    parameter int DATA_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          up_req_valid,
    output logic                          up_req_ready,
    input  logic                          up_req_rw,
    input  logic [ADDR_BITS-1:0]          up_req_addr,
    input  logic [TAG_BITS-1:0]           up_req_tag,
    input  logic                          up_data_valid,
    output logic                          up_data_ready,
    input  logic [DATA_BITS-1:0]          up_data_bits,
    input  logic [DATA_BITS/8-1:0]        up_data_mask,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_rw,
    output logic [ADDR_BITS-1:0]          mem_req_addr,
    output logic [TAG_BITS-1:0]           mem_req_tag,
    output logic                          mem_req_data_valid,
    input  logic                          mem_req_data_ready,
    output logic [DATA_BITS-1:0]          mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]        mem_req_data_mask,
    output logic [$clog2(REQ_DEPTH):0]    req_count,
    output logic [$clog2(DATA_DEPTH):0]   data_count
);

    localparam int RPW       = $clog2(REQ_DEPTH);
    localparam int DPW       = $clog2(DATA_DEPTH);
    localparam int RCW       = RPW + 1;
    localparam int DCW       = DPW + 1;
    localparam int MASK_BITS = DATA_BITS / 8;

    localparam logic [RCW-1:0] REQ_FULL  = RCW'(REQ_DEPTH);
    localparam logic [DCW-1:0] DATA_FULL = DCW'(DATA_DEPTH);
    localparam logic [DCW-1:0] BEATS_C   = DCW'(BEATS);

    // Request queue storage
    logic                 req_rw_mem   [REQ_DEPTH];
    logic [ADDR_BITS-1:0] req_addr_mem [REQ_DEPTH];
    logic [TAG_BITS-1:0]  req_tag_mem  [REQ_DEPTH];
    logic [RPW-1:0]       req_wr_ptr;
    logic [RPW-1:0]       req_rd_ptr;

    // Data queue storage
    logic [DATA_BITS-1:0] data_bits_mem [DATA_DEPTH];
    logic [MASK_BITS-1:0] data_mask_mem [DATA_DEPTH];
    logic [DPW-1:0]       data_wr_ptr;
    logic [DPW-1:0]       data_rd_ptr;

    // Beats still owed to write requests that have already gone downstream
    logic [DCW-1:0]       owed;
    logic [DCW-1:0]       free_beats;

    logic head_rw;
    logic req_enq;
    logic req_deq;
    logic data_enq;
    logic data_deq;
    logic write_issue;

    assign up_req_ready  = (req_count != REQ_FULL);
    assign up_data_ready = (data_count != DATA_FULL);

    assign free_beats = data_count - owed;
    assign head_rw    = req_rw_mem[req_rd_ptr];

    assign mem_req_valid = (req_count != '0) && (!head_rw || (free_beats >= BEATS_C));
    assign mem_req_rw    = head_rw;
    assign mem_req_addr  = req_addr_mem[req_rd_ptr];
    assign mem_req_tag   = req_tag_mem[req_rd_ptr];

    assign mem_req_data_valid = (data_count != '0) && (owed != '0);
    assign mem_req_data_bits  = data_bits_mem[data_rd_ptr];
    assign mem_req_data_mask  = data_mask_mem[data_rd_ptr];

    assign req_enq     = up_req_valid && up_req_ready;
    assign req_deq     = mem_req_valid && mem_req_ready;
    assign data_enq    = up_data_valid && up_data_ready;
    assign data_deq    = mem_req_data_valid && mem_req_data_ready;
    assign write_issue = req_deq && head_rw;

    // rw bits are reset so an empty queue never presents an unknown head type
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REQ_DEPTH; i++) begin
                req_rw_mem[i] <= 1'b0;
            end
        end else if (req_enq) begin
            req_rw_mem[req_wr_ptr] <= up_req_rw;
        end
    end

    // Request address/tag payload capture
    always_ff @(posedge clk) begin
        if (req_enq) begin
            req_addr_mem[req_wr_ptr] <= up_req_addr;
            req_tag_mem[req_wr_ptr]  <= up_req_tag;
        end
    end

    // Write-beat payload capture
    always_ff @(posedge clk) begin
        if (data_enq) begin
            data_bits_mem[data_wr_ptr] <= up_data_bits;
            data_mask_mem[data_wr_ptr] <= up_data_mask;
        end
    end

    // Request queue pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_count  <= '0;
        end else begin
            if (req_enq) begin
                req_wr_ptr <= req_wr_ptr + RPW'(1);
            end
            if (req_deq) begin
                req_rd_ptr <= req_rd_ptr + RPW'(1);
            end
            case ({req_enq, req_deq})
                2'b10:   req_count <= req_count + RCW'(1);
                2'b01:   req_count <= req_count - RCW'(1);
                default: req_count <= req_count;
            endcase
        end
    end

    // Data queue pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
            data_count  <= '0;
        end else begin
            if (data_enq) begin
                data_wr_ptr <= data_wr_ptr + DPW'(1);
            end
            if (data_deq) begin
                data_rd_ptr <= data_rd_ptr + DPW'(1);
            end
            case ({data_enq, data_deq})
                2'b10:   data_count <= data_count + DCW'(1);
                2'b01:   data_count <= data_count - DCW'(1);
                default: data_count <= data_count;
            endcase
        end
    end

    // A write issue claims a full line of beats; each beat sent pays one back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owed <= '0;
        end else begin
            case ({write_issue, data_deq})
                2'b10:   owed <= owed + BEATS_C;
                2'b01:   owed <= owed - DCW'(1);
                2'b11:   owed <= owed + BEATS_C - DCW'(1);
                default: owed <= owed;
            endcase
        end
    end

    a_owed_le_data : assert property (@(posedge clk) disable iff (reset) owed <= data_count);
    a_req_bound    : assert property (@(posedge clk) disable iff (reset) req_count <= REQ_FULL);
    a_data_bound   : assert property (@(posedge clk) disable iff (reset) data_count <= DATA_FULL);

endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: directed walk through the queue's ordering/backpressure
// scenarios followed by a random phase, all checked against a queue-level
// reference model of the buffer.
module tb_mem_req_queue;

    localparam int ADDR_BITS  = 28;
    localparam int TAG_BITS   = 5;
    localparam int DATA_BITS  = 128;
    localparam int BEATS      = 4;
    localparam int REQ_DEPTH  = 4;
    localparam int DATA_DEPTH = 8;

    logic                   clk;
    logic                   reset;
    logic                   up_req_valid;
    logic                   up_req_ready;
    logic                   up_req_rw;
    logic [ADDR_BITS-1:0]   up_req_addr;
    logic [TAG_BITS-1:0]    up_req_tag;
    logic                   up_data_valid;
    logic                   up_data_ready;
    logic [DATA_BITS-1:0]   up_data_bits;
    logic [DATA_BITS/8-1:0] up_data_mask;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_rw;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic [TAG_BITS-1:0]    mem_req_tag;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic [2:0]             req_count;
    logic [3:0]             data_count;

    mem_req_queue #(
        .ADDR_BITS  (ADDR_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_BITS  (DATA_BITS),
        .BEATS      (BEATS),
        .REQ_DEPTH  (REQ_DEPTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .up_req_valid       (up_req_valid),
        .up_req_ready       (up_req_ready),
        .up_req_rw          (up_req_rw),
        .up_req_addr        (up_req_addr),
        .up_req_tag         (up_req_tag),
        .up_data_valid      (up_data_valid),
        .up_data_ready      (up_data_ready),
        .up_data_bits       (up_data_bits),
        .up_data_mask       (up_data_mask),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .req_count          (req_count),
        .data_count         (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 rw;
        logic [ADDR_BITS-1:0] addr;
        logic [TAG_BITS-1:0]  tag;
    } req_t;

    typedef struct {
        logic [DATA_BITS-1:0]   bits;
        logic [DATA_BITS/8-1:0] mask;
    } beat_t;

    req_t  model_reqs[$];
    beat_t model_beats[$];
    int    model_owed;

    int vectors;
    int miscompares;
    bit req_taken;

    function automatic bit exp_req_valid();
        if (model_reqs.size() == 0) return 1'b0;
        if (!model_reqs[0].rw) return 1'b1;
        return (model_beats.size() - model_owed) >= BEATS;
    endfunction

    function automatic bit exp_data_valid();
        return (model_beats.size() != 0) && (model_owed != 0);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Compare every observable output against the model's view of the buffer
    task automatic checkAll();
        checkOutput("up_req_ready", up_req_ready, model_reqs.size() != REQ_DEPTH);
        checkOutput("up_data_ready", up_data_ready, model_beats.size() != DATA_DEPTH);
        checkOutput("req_count", req_count, model_reqs.size());
        checkOutput("data_count", data_count, model_beats.size());
        checkOutput("mem_req_valid", mem_req_valid, exp_req_valid());
        checkOutput("mem_req_data_valid", mem_req_data_valid, exp_data_valid());
        if (exp_req_valid()) begin
            checkOutput("mem_req_rw", mem_req_rw, model_reqs[0].rw);
            checkOutput("mem_req_addr", mem_req_addr, model_reqs[0].addr);
            checkOutput("mem_req_tag", mem_req_tag, model_reqs[0].tag);
        end
        if (exp_data_valid()) begin
            checkOutput("mem_req_data_bits", mem_req_data_bits, model_beats[0].bits);
            checkOutput("mem_req_data_mask", mem_req_data_mask, model_beats[0].mask);
        end
    endtask

    // One clock of stimulus: drive, check, clock, then advance the model
    task automatic applyStimulus(input logic rv, input logic rw, input logic [ADDR_BITS-1:0] addr,
                                 input logic [TAG_BITS-1:0] tag, input logic dv,
                                 input logic [DATA_BITS-1:0] bits, input logic [DATA_BITS/8-1:0] mask,
                                 input logic mrr, input logic mdr);
        bit    req_in, req_out, dat_in, dat_out;
        req_t  r;
        beat_t b;
        up_req_valid       = rv;
        up_req_rw          = rw;
        up_req_addr        = addr;
        up_req_tag         = tag;
        up_data_valid      = dv;
        up_data_bits       = bits;
        up_data_mask       = mask;
        mem_req_ready      = mrr;
        mem_req_data_ready = mdr;
        #1;
        checkAll();
        req_in  = rv && (model_reqs.size() != REQ_DEPTH);
        dat_in  = dv && (model_beats.size() != DATA_DEPTH);
        req_out = exp_req_valid() && mrr;
        dat_out = exp_data_valid() && mdr;
        @(posedge clk);
        if (req_out) begin
            if (model_reqs[0].rw) model_owed += BEATS;
            model_reqs.delete(0);
        end
        if (dat_out) begin
            model_beats.delete(0);
            model_owed--;
        end
        if (req_in) begin
            r.rw = rw; r.addr = addr; r.tag = tag;
            model_reqs.push_back(r);
        end
        if (dat_in) begin
            b.bits = bits; b.mask = mask;
            model_beats.push_back(b);
        end
        req_taken = req_in;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic mrr, input logic mdr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, mrr, mdr);
        end
    endtask

    // Assert reset between clock edges and check it takes effect immediately
    task automatic asyncReset();
        up_req_valid  = 1'b0;
        up_data_valid = 1'b0;
        #2;
        reset = 1'b1;
        model_reqs.delete();
        model_beats.delete();
        model_owed = 0;
        #1;
        checkAll();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pushed;
        int tries;
        vectors     = 0;
        miscompares = 0;
        model_owed  = 0;
        req_taken   = 1'b0;
        reset              = 1'b1;
        up_req_valid       = 1'b0;
        up_req_rw          = 1'b0;
        up_req_addr        = '0;
        up_req_tag         = '0;
        up_data_valid      = 1'b0;
        up_data_bits       = '0;
        up_data_mask       = '0;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;

        $display("[TB] reset state");
        @(negedge clk);
        @(negedge clk);
        checkAll();
        reset = 1'b0;

        $display("[TB] single read");
        applyStimulus(1'b1, 1'b0, 28'h0000100, 5'd3, 1'b0, '0, '0, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        $display("[TB] write before its beats");
        applyStimulus(1'b1, 1'b1, 28'h0000200, 5'd1, 1'b0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 128'(32'hA + i), 16'h000F << (4 * i), 1'b1, 1'b1);
        end
        idle(6, 1'b1, 1'b1);

        $display("[TB] request queue full");
        pushed = 0;
        tries  = 0;
        while (pushed < 5 && tries < 20) begin
            applyStimulus(1'b1, 1'b0, 28'(32'h300 + pushed), 5'(10 + pushed), 1'b0, '0, '0, tries >= 6, 1'b1);
            if (req_taken) pushed++;
            tries++;
        end
        checkOutput("reads_accepted", 128'(pushed), 128'd5);
        idle(5, 1'b1, 1'b1);

        $display("[TB] data queue full and wrap");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(k < 2, 1'b1, 28'(32'h400 + k), 5'(20 + k), 1'b1, 128'(32'h100 + k), 16'(32'h1111 * (k + 1)), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 128'h999, 16'hFFFF, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(10, 1'b1, 1'b1);

        $display("[TB] read blocked behind write");
        applyStimulus(1'b1, 1'b1, 28'h0000500, 5'd5, 1'b0, '0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 28'h0000600, 5'd6, 1'b0, '0, '0, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 128'(32'h50 + i), 16'hA5A5 ^ 16'(i), 1'b1, 1'b1);
        end
        idle(8, 1'b1, 1'b1);

        $display("[TB] reset with buffered state");
        applyStimulus(1'b1, 1'b1, 28'h0000700, 5'd7, 1'b1, 128'h70, 16'h0001, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 128'(32'h70 + i), 16'h0001 << i, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 28'(32'h710 + i), 5'(i), 1'b0, '0, '0, 1'b0, 1'b0);
        end
        idle(1, 1'b0, 1'b0);
        asyncReset();
        applyStimulus(1'b1, 1'b0, 28'h0000800, 5'd8, 1'b0, '0, '0, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                asyncReset();
            end
            applyStimulus($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 28'($urandom),
                          5'($urandom), $urandom_range(0, 3) != 0,
                          {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end
        idle(20, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_req_queue.md
Name: mem_req_queue

Overview:
- Decoupling buffer between the memory-system request side (arbiter request channel plus dcache write-data channel) and the external main memory interface.
- Holds up to REQ_DEPTH requests and DATA_DEPTH write-data beats, so cache/arbiter stalls do not follow every main-memory backpressure cycle.
- Enforces write ordering: a write request goes downstream only when its full line of data beats is already buffered.
- Data beats go downstream only after their owning write request has issued.

Parameters:
- ADDR_BITS, 28, request address width (`MEM_ADDR_BITS)
- TAG_BITS, 5, request tag width (`MEM_TAG_BITS)
- DATA_BITS, 128, data beat width (`MEM_DATA_BITS)
- BEATS, 4, data beats per write request (one cache line)
- REQ_DEPTH, 4, request queue entries, power of two, ≥2
- DATA_DEPTH, 8, data queue entries, power of two, ≥BEATS

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- up_req_valid  in  1  upstream request valid
- up_req_ready  out  1  request queue can accept
- up_req_rw  in  1  1=write, 0=read
- up_req_addr  in  ADDR_BITS  request address
- up_req_tag  in  TAG_BITS  request tag
- up_data_valid  in  1  upstream write beat valid
- up_data_ready  out  1  data queue can accept
- up_data_bits  in  DATA_BITS  write beat
- up_data_mask  in  DATA_BITS/8  byte mask
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_rw  out  1  head request rw
- mem_req_addr  out  ADDR_BITS  head request address
- mem_req_tag  out  TAG_BITS  head request tag
- mem_req_data_valid  out  1  downstream beat valid
- mem_req_data_ready  in  1  memory accepts beat
- mem_req_data_bits  out  DATA_BITS  head beat
- mem_req_data_mask  out  DATA_BITS/8  head mask
- req_count  out  clog2(REQ_DEPTH)+1  request occupancy
- data_count  out  clog2(DATA_DEPTH)+1  data occupancy

Behaviour:
- Reset (async assert, sync release):
  - Both queues empty; pointers and counts are 0; owed = 0.
  - up_req_ready = 1, up_data_ready = 1; every mem_* valid = 0.
  - Data/address outputs are don't-care but must not be X-propagating from an uninitialised valid.
- Reset mid-operation discards all buffered requests and beats immediately.
- Transfers occur on the rising clk edge when valid && ready.
- Queues: circular buffers with read/write pointers that wrap modulo depth, plus occupancy counters.
  - up_req_ready = (req_count != REQ_DEPTH).
  - up_data_ready = (data_count != DATA_DEPTH).
  - Ready depends only on registered state. There is no same-cycle pass-through of a dequeue, so a full queue refuses enqueue even while dequeuing.
- Latency: an entry enqueued into an empty queue is visible at the mem_* outputs in the next cycle. Downstream outputs come from storage/registers only, with no combinational path from up_* to mem_*.
- owed counter, 0..DATA_DEPTH: beats owed to writes already issued downstream.
  - Increments by BEATS when a write request fires on mem_req.
  - Decrements by 1 on each mem_req_data fire.
  - Same-cycle issue and beat fire gives owed + BEATS - 1.
- free_beats = data_count - owed.
- mem_req_valid = req not empty && (head.rw == 0 || free_beats ≥ BEATS).
  - A read at the head is never blocked by data.
  - A write at the head blocks all requests behind it; requests stay strictly in order.
- mem_req_data_valid = data not empty && owed != 0. Beats are never presented ahead of their request.
- Simultaneous enqueue and dequeue on the same queue:
  - Count is unchanged.
  - Both pointers advance.
  - Only legal when the queue is not full (enqueue side) and not empty (dequeue side).
- Upstream protocol error (more beats than BEATS × writes): excess beats sit in the queue until later writes claim them. No error flag.
- Invariants, checked by assertions:
  - owed ≤ data_count.
  - req_count ≤ REQ_DEPTH.
  - data_count ≤ DATA_DEPTH.

Test Plan:
1. Reset, then one read (addr 0x0000100, tag 3) with mem_req_ready = 1 → mem_req_valid rises the next cycle with rw = 0, addr 0x0000100, tag 3; fires; req_count returns to 0; data channel stays invalid.
2. Write request (addr 0x0000200, tag 1) presented before its beats, then beats 0xA..0xD one per cycle → mem_req_valid stays 0 until the 4th beat is buffered. Once the request fires, beats A, B, C, D appear in order with masks intact; owed goes 4→0.
3. Hold mem_req_ready = 0 and push 5 reads → up_req_ready drops after the 4th accept (req_count = 4). The 5th stays pending until one dequeue, then is accepted the following cycle.
4. Hold mem_req_data_ready = 0 with 2 writes issued and 8 beats → data_count = 8, up_data_ready = 0. Releasing ready drains 8 beats in order across the pointer wrap.
5. Write at head lacking beats, read behind it → the read is not issued until the write's 4 beats arrive and the write fires; the read then issues on the next cycle.
6. Assert reset while 3 requests and 5 beats are buffered with owed = 4 → all valids drop asynchronously; counts and owed read 0; the first post-reset read is issued normally.
